// File: rtl/miri_pkg.sv
// rtl/miri_pkg.sv - shared opcodes, ALU/immediate enums and immediate builder for the decode stage
package miri_pkg;

    localparam int          XLEN   = 32;
    localparam int          NREGS  = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_PASS
    } alu_op_t;

    typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_type_t;

    // Every format sign-extends from instruction bit 31
    function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_type_t t);
        logic [31:0] r;
        r = '0;
        case (t)
            IMM_I:   r = {{20{i[31]}}, i[31:20]};
            IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - register file, two async read ports, one sync write port, write-through bypass
module reg_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_hit;

    assign wr_hit = we && (waddr != '0);

    // Clear on reset; x0 is never written so it stays zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREGS; k++) regs[k] <= '0;
        end else if (wr_hit) begin
            regs[waddr] <= wdata;
        end
    end

    // Reads see the value being written this cycle so decode never picks up a stale operand
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (wr_hit && waddr == raddr1) rdata1 = wdata;
        if (wr_hit && waddr == raddr2) rdata2 = wdata;
        if (raddr1 == '0) rdata1 = '0;
        if (raddr2 == '0) rdata2 = '0;
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I subset decoder, load-use hazard detect and D/E stage register
module decode_stage
    import miri_pkg::*;
#(
    parameter int          XLEN   = miri_pkg::XLEN,
    parameter int          NREGS  = miri_pkg::NREGS,
    parameter logic [31:0] RST_PC = miri_pkg::RST_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            EN_REG,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc_in,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_rd,
    output logic            stall,
    output logic            valid_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rd,
    output logic [3:0]      alu_op,
    output logic            alu_src_imm,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem_byte,
    output logic            reg_write,
    output logic            is_branch,
    output logic            is_jump,
    output logic            illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1_a, rs2_a, rd_a;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];
    assign rs1_a  = instruction[19:15];
    assign rs2_a  = instruction[24:20];
    assign rd_a   = instruction[11:7];

    logic [XLEN-1:0] rf_rd1, rf_rd2;

    reg_file #(.XLEN(XLEN), .NREGS(NREGS), .AW(5)) u_reg_file (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rs1_a),
        .rdata1 (rf_rd1),
        .raddr2 (rs2_a),
        .rdata2 (rf_rd2)
    );

    logic      legal, use1, use2, has_imm;
    logic      d_src, d_mr, d_mw, d_mb, d_rw, d_br, d_j;
    alu_op_t   d_alu;
    imm_type_t d_imm_t;
    logic [4:0]      d_rd;
    logic [XLEN-1:0] d_imm;

    // Instruction decode; anything not recognised collapses to an all-zero control word
    always_comb begin
        legal = 1'b0; use1 = 1'b0; use2 = 1'b0; has_imm = 1'b0;
        d_src = 1'b0; d_mr = 1'b0; d_mw = 1'b0; d_mb = 1'b0;
        d_rw = 1'b0; d_br = 1'b0; d_j = 1'b0;
        d_alu = ALU_ADD; d_imm_t = IMM_I;
        case (opcode)
            OP_R: begin
                use1 = 1'b1; use2 = 1'b1; d_rw = 1'b1; legal = (funct7 == F7_BASE);
                case (funct3)
                    3'b000: begin
                        d_alu = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                        legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    3'b001: d_alu = ALU_SLL;
                    3'b010: d_alu = ALU_SLT;
                    3'b100: d_alu = ALU_XOR;
                    3'b101: begin
                        d_alu = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    3'b110: d_alu = ALU_OR;
                    3'b111: d_alu = ALU_AND;
                    default: legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                use1 = 1'b1; d_rw = 1'b1; d_src = 1'b1; has_imm = 1'b1; legal = 1'b1;
                case (funct3)
                    3'b000: d_alu = ALU_ADD;
                    3'b010: d_alu = ALU_SLT;
                    3'b100: d_alu = ALU_XOR;
                    3'b110: d_alu = ALU_OR;
                    3'b111: d_alu = ALU_AND;
                    3'b001: begin
                        d_alu = ALU_SLL;
                        legal = (funct7 == F7_BASE);
                    end
                    3'b101: begin
                        d_alu = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                use1 = 1'b1; d_rw = 1'b1; d_mr = 1'b1; d_src = 1'b1; has_imm = 1'b1;
                d_mb = (funct3 == 3'b000);
                legal = (funct3 == 3'b000) || (funct3 == 3'b010);
            end
            OP_STORE: begin
                use1 = 1'b1; use2 = 1'b1; d_mw = 1'b1; d_src = 1'b1; has_imm = 1'b1;
                d_imm_t = IMM_S; d_mb = (funct3 == 3'b000);
                legal = (funct3 == 3'b000) || (funct3 == 3'b010);
            end
            OP_BRANCH: begin
                use1 = 1'b1; use2 = 1'b1; d_br = 1'b1; d_alu = ALU_SUB; has_imm = 1'b1;
                d_imm_t = IMM_B; legal = (funct3 == 3'b000);
            end
            OP_JAL: begin
                d_j = 1'b1; d_rw = 1'b1; d_alu = ALU_PASS; has_imm = 1'b1;
                d_imm_t = IMM_J; legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            use1 = 1'b0; use2 = 1'b0; has_imm = 1'b0;
            d_src = 1'b0; d_mr = 1'b0; d_mw = 1'b0; d_mb = 1'b0;
            d_rw = 1'b0; d_br = 1'b0; d_j = 1'b0; d_alu = ALU_ADD;
        end
        d_rd  = d_rw ? rd_a : 5'd0;
        d_imm = has_imm ? gen_imm(instruction, d_imm_t) : '0;
    end

    // Load-use hazard: hold fetch while the load in EX produces a source of this instruction
    assign stall = ex_is_load && (ex_rd != 5'd0) && !flush && !reset &&
                   ((use1 && rs1_a == ex_rd) || (use2 && rs2_a == ex_rd));

    // D/E register: reset > flush bubble > hold > stall bubble > load
    always_ff @(posedge clk) begin
        if (reset || flush || (EN_REG && stall)) begin
            valid_out   <= 1'b0;
            pc_out      <= RST_PC;
            rs1_data    <= '0;
            rs2_data    <= '0;
            imm         <= '0;
            rd          <= 5'd0;
            alu_op      <= ALU_ADD;
            alu_src_imm <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_byte    <= 1'b0;
            reg_write   <= 1'b0;
            is_branch   <= 1'b0;
            is_jump     <= 1'b0;
            illegal     <= 1'b0;
        end else if (EN_REG) begin
            valid_out   <= 1'b1;
            pc_out      <= pc_in;
            rs1_data    <= rf_rd1;
            rs2_data    <= rf_rd2;
            imm         <= d_imm;
            rd          <= d_rd;
            alu_op      <= d_alu;
            alu_src_imm <= d_src;
            mem_read    <= d_mr;
            mem_write   <= d_mw;
            mem_byte    <= d_mb;
            reg_write   <= d_rw;
            is_branch   <= d_br;
            is_jump     <= d_j;
            illegal     <= !legal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized and directed checks of decode_stage against a mnemonic-level model
module tb_decode_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic        src, mr, mw, mb, rw, br, j, ill;
    } exp_t;

    // ALU op numbering as listed: ADD SUB AND OR XOR SLL SRL SRA SLT PASS
    localparam logic [3:0] A_ADD = 0, A_SUB = 1, A_AND = 2, A_OR = 3, A_XOR = 4,
                           A_SLL = 5, A_SRL = 6, A_SRA = 7, A_SLT = 8, A_PASS = 9;

    logic        clk, reset, flush, en;
    logic [31:0] instruction, pc_in, wb_data;
    logic        wb_en, ex_is_load;
    logic [4:0]  wb_addr, ex_rd;
    logic        stall, valid_out, alu_src_imm, mem_read, mem_write, mem_byte;
    logic        reg_write, is_branch, is_jump, illegal;
    logic [31:0] pc_out, rs1_data, rs2_data, imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;

    decode_stage dut (
        .clk(clk), .reset(reset), .flush(flush), .EN_REG(en),
        .instruction(instruction), .pc_in(pc_in),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .stall(stall),
        .valid_out(valid_out), .pc_out(pc_out), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .rd(rd), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte(mem_byte),
        .reg_write(reg_write), .is_branch(is_branch), .is_jump(is_jump), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mregs [32];
    exp_t        cur;
    int          tests, fails;

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] r2, logic [4:0] r1,
                                          logic [2:0] f3, logic [4:0] d, logic [6:0] op);
        return {f7, r2, r1, f3, d, op};
    endfunction
    function automatic logic [31:0] enc_i(logic [11:0] im, logic [4:0] r1, logic [2:0] f3,
                                          logic [4:0] d, logic [6:0] op);
        return {im, r1, f3, d, op};
    endfunction
    function automatic logic [31:0] enc_s(logic [11:0] im, logic [4:0] r2, logic [4:0] r1, logic [2:0] f3);
        return {im[11:5], r2, r1, f3, im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(logic [12:0] im, logic [4:0] r2, logic [4:0] r1);
        return {im[12], im[10:5], r2, r1, 3'b000, im[4:1], im[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(logic [20:0] im, logic [4:0] d);
        return {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "/valid"}, 32'(valid_out), 32'(cur.valid));
        chk({tag, "/pc"}, pc_out, cur.pc);
        chk({tag, "/rs1"}, rs1_data, cur.rs1);
        chk({tag, "/rs2"}, rs2_data, cur.rs2);
        chk({tag, "/imm"}, imm, cur.imm);
        chk({tag, "/rd"}, 32'(rd), 32'(cur.rd));
        chk({tag, "/alu"}, 32'(alu_op), 32'(cur.alu));
        chk({tag, "/ctl"},
            32'({alu_src_imm, mem_read, mem_write, mem_byte, reg_write, is_branch, is_jump, illegal}),
            32'({cur.src, cur.mr, cur.mw, cur.mb, cur.rw, cur.br, cur.j, cur.ill}));
    endtask

    // One clock: model regfile write, predict stall and stage register, then check both
    task automatic run_cycle(input logic [31:0] ins, input exp_t dec, input bit u1, input bit u2,
                             input string tag);
        logic s_exp;
        instruction = ins;
        if (wb_en && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
        dec.pc  = pc_in;
        dec.rs1 = mregs[ins[19:15]];
        dec.rs2 = mregs[ins[24:20]];
        s_exp = ex_is_load && ex_rd != 5'd0 && !flush &&
                ((u1 && ins[19:15] == ex_rd) || (u2 && ins[24:20] == ex_rd));
        #1;
        chk({tag, "/stall"}, 32'(stall), 32'(s_exp));
        if (flush)      cur = '0;
        else if (!en)   cur = cur;
        else if (s_exp) cur = '0;
        else            cur = dec;
        @(posedge clk); #1;
        check_outs(tag);
    endtask

    // Random instruction of a class, with expectations derived from the mnemonic chosen
    task automatic gen(input int kind, output logic [31:0] ins, output exp_t e,
                       output bit u1, output bit u2);
        logic [4:0] r1, r2, d;
        logic [2:0] f3;
        logic [6:0] f7;
        int idx, iv;
        r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 31));
        e = '0; e.valid = 1'b1; u1 = 1'b0; u2 = 1'b0; f7 = 7'd0; f3 = 3'd0;
        case (kind)
            0: begin
                idx = $urandom_range(0, 8);
                case (idx)
                    0: begin f3 = 3'b000; e.alu = A_ADD; end
                    1: begin f3 = 3'b000; f7 = 7'h20; e.alu = A_SUB; end
                    2: begin f3 = 3'b001; e.alu = A_SLL; end
                    3: begin f3 = 3'b010; e.alu = A_SLT; end
                    4: begin f3 = 3'b100; e.alu = A_XOR; end
                    5: begin f3 = 3'b101; e.alu = A_SRL; end
                    6: begin f3 = 3'b101; f7 = 7'h20; e.alu = A_SRA; end
                    7: begin f3 = 3'b110; e.alu = A_OR; end
                    default: begin f3 = 3'b111; e.alu = A_AND; end
                endcase
                ins = enc_r(f7, r2, r1, f3, d, 7'b0110011);
                e.rd = d; e.rw = 1'b1; u1 = 1'b1; u2 = 1'b1;
            end
            1: begin
                idx = $urandom_range(0, 7);
                iv = $urandom_range(0, 4095) - 2048;
                case (idx)
                    0: begin f3 = 3'b000; e.alu = A_ADD; end
                    1: begin f3 = 3'b010; e.alu = A_SLT; end
                    2: begin f3 = 3'b100; e.alu = A_XOR; end
                    3: begin f3 = 3'b110; e.alu = A_OR; end
                    4: begin f3 = 3'b111; e.alu = A_AND; end
                    5: begin f3 = 3'b001; e.alu = A_SLL; iv = $urandom_range(0, 31); end
                    6: begin f3 = 3'b101; e.alu = A_SRL; iv = $urandom_range(0, 31); end
                    default: begin f3 = 3'b101; e.alu = A_SRA; iv = 1024 + $urandom_range(0, 31); end
                endcase
                ins = enc_i(12'(iv), r1, f3, d, 7'b0010011);
                e.imm = 32'(iv); e.rd = d; e.rw = 1'b1; e.src = 1'b1; u1 = 1'b1;
            end
            2: begin
                iv = $urandom_range(0, 4095) - 2048;
                e.mb = 1'($urandom_range(0, 1));
                ins = enc_i(12'(iv), r1, e.mb ? 3'b000 : 3'b010, d, 7'b0000011);
                e.imm = 32'(iv); e.rd = d; e.rw = 1'b1; e.mr = 1'b1; e.src = 1'b1;
                e.alu = A_ADD; u1 = 1'b1;
            end
            3: begin
                iv = $urandom_range(0, 4095) - 2048;
                e.mb = 1'($urandom_range(0, 1));
                ins = enc_s(12'(iv), r2, r1, e.mb ? 3'b000 : 3'b010);
                e.imm = 32'(iv); e.mw = 1'b1; e.src = 1'b1; e.alu = A_ADD; u1 = 1'b1; u2 = 1'b1;
            end
            4: begin
                iv = ($urandom_range(0, 4095) - 2048) * 2;
                ins = enc_b(13'(iv), r2, r1);
                e.imm = 32'(iv); e.br = 1'b1; e.alu = A_SUB; u1 = 1'b1; u2 = 1'b1;
            end
            5: begin
                iv = ($urandom_range(0, 1048575) - 524288) * 2;
                ins = enc_j(21'(iv), d);
                e.imm = 32'(iv); e.j = 1'b1; e.rw = 1'b1; e.rd = d; e.alu = A_PASS;
            end
            default: begin
                idx = $urandom_range(0, 4);
                case (idx)
                    0: ins = {$urandom_range(0, 33554431), 7'h7F} & 32'hFFFFFFFF;
                    1: ins = 32'h0;
                    2: ins = enc_r(7'b0000001, r2, r1, 3'b000, d, 7'b0110011);
                    3: ins = enc_i(12'($urandom), r1, 3'b011, d, 7'b0000011);
                    default: ins = enc_i(12'($urandom), r1, 3'b011, d, 7'b0010011);
                endcase
                e.ill = 1'b1;
            end
        endcase
    endtask

    logic [31:0] ins;
    exp_t        e;
    bit          u1, u2;

    initial begin
        tests = 0; fails = 0;
        for (int k = 0; k < 32; k++) mregs[k] = '0;
        reset = 1'b1; flush = 1'b0; en = 1'b1; instruction = '0; pc_in = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; ex_is_load = 1'b0; ex_rd = '0;
        cur = '0;

        // Reset: hazard inputs present yet stall must stay low; outputs all zero
        @(posedge clk); #1;
        ex_is_load = 1'b1; ex_rd = 5'd1; instruction = enc_r(7'd0, 5'd1, 5'd1, 3'b000, 5'd2, 7'b0110011);
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hDEAD_BEEF;
        #1; chk("reset_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("reset_stall2", 32'(stall), 32'd0);
        check_outs("reset");
        reset = 1'b0; ex_is_load = 1'b0; wb_en = 1'b0;

        for (int i = 1; i < 32; i++) begin
            pc_in = 32'(i * 4);
            e = '0; e.valid = 1'b1; e.rw = 1'b1; e.alu = A_ADD;
            run_cycle(enc_r(7'd0, 5'(i), 5'(i), 3'b000, 5'd0, 7'b0110011), e, 1'b1, 1'b1, "rf_zero");
        end

        // Writeback bypass into same-cycle decode
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234; pc_in = 32'h100;
        e = '0; e.valid = 1'b1; e.rw = 1'b1; e.rd = 5'd7; e.alu = A_ADD;
        run_cycle(enc_r(7'd0, 5'd5, 5'd5, 3'b000, 5'd7, 7'b0110011), e, 1'b1, 1'b1, "bypass");
        chk("bypass_rs1", rs1_data, 32'h1234);
        chk("bypass_rd", 32'(rd), 32'd7);
        wb_en = 1'b0;

        // Load-use stall then release
        ex_is_load = 1'b1; ex_rd = 5'd5; pc_in = 32'h104;
        e = '0; e.valid = 1'b1; e.rw = 1'b1; e.rd = 5'd6; e.src = 1'b1; e.imm = 32'hFFFF_FFFF; e.alu = A_ADD;
        run_cycle(enc_i(12'hFFF, 5'd5, 3'b000, 5'd6, 7'b0010011), e, 1'b1, 1'b0, "stall");
        chk("stall_bubble", 32'(valid_out), 32'd0);
        ex_is_load = 1'b0;
        run_cycle(enc_i(12'hFFF, 5'd5, 3'b000, 5'd6, 7'b0010011), e, 1'b1, 1'b0, "release");
        chk("release_imm", imm, 32'hFFFF_FFFF);

        // Flush overrides stall
        ex_is_load = 1'b1; flush = 1'b1;
        run_cycle(enc_i(12'hFFF, 5'd5, 3'b000, 5'd6, 7'b0010011), e, 1'b1, 1'b0, "flush");
        flush = 1'b0; ex_is_load = 1'b0;

        // Store, hold, branch, jump immediates
        pc_in = 32'h200;
        e = '0; e.valid = 1'b1; e.mw = 1'b1; e.src = 1'b1; e.imm = 32'hFFFF_FFFC; e.alu = A_ADD;
        run_cycle(enc_s(12'hFFC, 5'd2, 5'd3, 3'b010), e, 1'b1, 1'b1, "sw");
        en = 1'b0; pc_in = 32'h204;
        e = '0; e.valid = 1'b1; e.br = 1'b1; e.alu = A_SUB; e.imm = 32'hFFFF_FFF8;
        run_cycle(enc_b(13'h1FF8, 5'd2, 5'd1), e, 1'b1, 1'b1, "hold");
        chk("hold_imm", imm, 32'hFFFF_FFFC);
        en = 1'b1;
        run_cycle(enc_b(13'h1FF8, 5'd2, 5'd1), e, 1'b1, 1'b1, "beq");
        chk("beq_imm", imm, 32'hFFFF_FFF8);
        e = '0; e.valid = 1'b1; e.j = 1'b1; e.rw = 1'b1; e.rd = 5'd1; e.alu = A_PASS; e.imm = 32'h800;
        run_cycle(enc_j(21'd2048, 5'd1), e, 1'b0, 1'b0, "jal");
        chk("jal_imm", imm, 32'h800);

        // x0 write discarded; illegal encodings
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_FFFF;
        e = '0; e.valid = 1'b1; e.rw = 1'b1; e.rd = 5'd1; e.alu = A_ADD;
        run_cycle(enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd1, 7'b0110011), e, 1'b1, 1'b1, "x0_wr");
        wb_en = 1'b0;
        run_cycle(enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd1, 7'b0110011), e, 1'b1, 1'b1, "x0_rd");
        chk("x0_rs1", rs1_data, 32'd0);
        e = '0; e.valid = 1'b1; e.ill = 1'b1;
        run_cycle(32'h0000_007F, e, 1'b0, 1'b0, "op7f");
        chk("op7f_ill", 32'({illegal, reg_write}), 32'b10);
        run_cycle(32'h0000_0000, e, 1'b0, 1'b0, "zero_ins");

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            wb_en = 1'($urandom_range(0, 1));
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            ex_is_load = ($urandom_range(0, 9) < 3);
            ex_rd = 5'($urandom_range(0, 7));
            flush = ($urandom_range(0, 9) == 0);
            en = ($urandom_range(0, 19) != 0);
            pc_in = $urandom & 32'hFFFF_FFFC;
            gen($urandom_range(0, 6), ins, e, u1, u2);
            run_cycle(ins, e, u1, u2, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
